// File: rtl/alu_input_ctrl.sv
// Operand/operation sequencer between push-button debouncers and the ALU.
// Captures operand A, then operand B, then cycles ADD/SUB/MOD on each enter press.
module alu_input_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OP_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enter_pulse,
  input  logic             sign_pulse,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b,
  output logic [OP_W-1:0]  alu_op,
  output logic             sign_mode,
  output logic [1:0]       state_led,
  output logic             op_strobe
);

  typedef enum logic [1:0] {
    S_WAIT_A = 2'b00,
    S_WAIT_B = 2'b01,
    S_RUN    = 2'b10
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(2'b00);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(2'b01);
  localparam logic [OP_W-1:0] OP_MOD  = OP_W'(2'b10);
  localparam logic [OP_W-1:0] OP_NONE = OP_W'(2'b11);

  state_t           r_state;
  logic [WIDTH-1:0] r_reg_a;
  logic [WIDTH-1:0] r_reg_b;
  logic [OP_W-1:0]  r_alu_op;
  logic [OP_W-1:0]  r_alu_op_q;
  logic             r_sign_mode;
  logic             r_op_strobe;

  // Sequencer, sign toggle and delayed op-change strobe; every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_WAIT_A;
      r_reg_a     <= '0;
      r_reg_b     <= '0;
      r_alu_op    <= OP_NONE;
      r_alu_op_q  <= OP_NONE;
      r_sign_mode <= 1'b0;
      r_op_strobe <= 1'b0;
    end else begin
      // Strobe fires the cycle after alu_op took a new value.
      r_alu_op_q  <= r_alu_op;
      r_op_strobe <= (r_alu_op != r_alu_op_q);

      if (sign_pulse) begin
        r_sign_mode <= ~r_sign_mode;
      end

      if (enter_pulse) begin
        case (r_state)
          S_WAIT_A: begin
            r_reg_a <= sw;
            r_state <= S_WAIT_B;
          end
          S_WAIT_B: begin
            r_reg_b  <= sw;
            r_alu_op <= OP_ADD;
            r_state  <= S_RUN;
          end
          S_RUN: begin
            case (r_alu_op)
              OP_ADD:  r_alu_op <= OP_SUB;
              OP_SUB:  r_alu_op <= OP_MOD;
              default: r_alu_op <= OP_ADD;
            endcase
          end
          default: r_state <= S_WAIT_A;
        endcase
      end
    end
  end

  assign reg_a     = r_reg_a;
  assign reg_b     = r_reg_b;
  assign alu_op    = r_alu_op;
  assign sign_mode = r_sign_mode;
  assign state_led = r_state;
  assign op_strobe = r_op_strobe;

endmodule

// File: tb/tb_alu_input_ctrl.sv
// Directed self-checking bench for alu_input_ctrl.
module tb_alu_input_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enter_pulse = 1'b0;
  logic       sign_pulse = 1'b0;
  logic [7:0] sw = 8'h00;
  logic [7:0] reg_a;
  logic [7:0] reg_b;
  logic [1:0] alu_op;
  logic       sign_mode;
  logic [1:0] state_led;
  logic       op_strobe;

  int n_pass = 0;
  int n_total = 0;

  alu_input_ctrl #(.WIDTH(8), .OP_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .enter_pulse(enter_pulse), .sign_pulse(sign_pulse),
    .sw(sw), .reg_a(reg_a), .reg_b(reg_b), .alu_op(alu_op), .sign_mode(sign_mode),
    .state_led(state_led), .op_strobe(op_strobe)
  );

  always #5 clk = ~clk;

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic step(input logic e, input logic s, input logic [7:0] v);
    enter_pulse = e;
    sign_pulse  = s;
    sw          = v;
    @(posedge clk);
    #1;
    enter_pulse = 1'b0;
    sign_pulse  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_total++; if (reg_a !== 8'h00) $display("FAIL reset_reg_a got %h exp 00", reg_a); else n_pass++;
    n_total++; if (reg_b !== 8'h00) $display("FAIL reset_reg_b got %h exp 00", reg_b); else n_pass++;
    n_total++; if (alu_op !== 2'b11) $display("FAIL reset_alu_op got %b exp 11", alu_op); else n_pass++;
    n_total++; if (sign_mode !== 1'b0) $display("FAIL reset_sign got %b exp 0", sign_mode); else n_pass++;
    n_total++; if (state_led !== 2'b00) $display("FAIL reset_state got %b exp 00", state_led); else n_pass++;
    n_total++; if (op_strobe !== 1'b0) $display("FAIL reset_strobe got %b exp 0", op_strobe); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_capture();
    step(1'b1, 1'b0, 8'h05);
    n_total++; if (reg_a !== 8'h05) $display("FAIL cap_a got %h exp 05", reg_a); else n_pass++;
    n_total++; if (state_led !== 2'b01) $display("FAIL cap_state_b got %b exp 01", state_led); else n_pass++;
    n_total++; if (alu_op !== 2'b11) $display("FAIL cap_op_none got %b exp 11", alu_op); else n_pass++;
    step(1'b1, 1'b0, 8'hFA);
    n_total++; if (reg_b !== 8'hFA) $display("FAIL cap_b got %h exp FA", reg_b); else n_pass++;
    n_total++; if (reg_a !== 8'h05) $display("FAIL cap_a_hold got %h exp 05", reg_a); else n_pass++;
    n_total++; if (alu_op !== 2'b00) $display("FAIL cap_op_add got %b exp 00", alu_op); else n_pass++;
    n_total++; if (state_led !== 2'b10) $display("FAIL cap_state_run got %b exp 10", state_led); else n_pass++;
    n_total++; if (op_strobe !== 1'b0) $display("FAIL cap_strobe_early got %b exp 0", op_strobe); else n_pass++;
    step(1'b0, 1'b0, 8'hFA);
    n_total++; if (op_strobe !== 1'b1) $display("FAIL cap_strobe got %b exp 1", op_strobe); else n_pass++;
    step(1'b0, 1'b0, 8'hFA);
    n_total++; if (op_strobe !== 1'b0) $display("FAIL cap_strobe_once got %b exp 0", op_strobe); else n_pass++;
  endtask

  task automatic test_run_steps();
    logic [1:0] exp_op [4] = '{2'b01, 2'b10, 2'b00, 2'b01};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 8'(i * 37 + 3));
      n_total++; if (alu_op !== exp_op[i]) $display("FAIL run_op[%0d] got %b exp %b", i, alu_op, exp_op[i]); else n_pass++;
      step(1'b0, 1'b0, 8'h00);
      n_total++; if (op_strobe !== 1'b1) $display("FAIL run_strobe[%0d] got %b exp 1", i, op_strobe); else n_pass++;
      n_total++; if (reg_a !== 8'h05 || reg_b !== 8'hFA)
        $display("FAIL run_operands[%0d] got %h/%h exp 05/FA", i, reg_a, reg_b); else n_pass++;
      step(1'b0, 1'b0, 8'h00);
      n_total++; if (op_strobe !== 1'b0) $display("FAIL run_strobe_off[%0d] got %b exp 0", i, op_strobe); else n_pass++;
    end
  endtask

  task automatic test_sign_and_enter();
    do_reset();
    step(1'b1, 1'b0, 8'h33);
    n_total++; if (state_led !== 2'b01) $display("FAIL se_state_b got %b exp 01", state_led); else n_pass++;
    step(1'b1, 1'b1, 8'h44);
    n_total++; if (sign_mode !== 1'b1) $display("FAIL se_sign got %b exp 1", sign_mode); else n_pass++;
    n_total++; if (reg_b !== 8'h44) $display("FAIL se_reg_b got %h exp 44", reg_b); else n_pass++;
    n_total++; if (state_led !== 2'b10) $display("FAIL se_state_run got %b exp 10", state_led); else n_pass++;
    n_total++; if (reg_a !== 8'h33) $display("FAIL se_reg_a got %h exp 33", reg_a); else n_pass++;
    step(1'b0, 1'b0, 8'h44);
    n_total++; if (op_strobe !== 1'b1) $display("FAIL se_strobe got %b exp 1", op_strobe); else n_pass++;
  endtask

  task automatic test_sw_noise();
    int errs = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 1'b0, 8'($urandom));
      if (reg_a !== 8'h33 || reg_b !== 8'h44 || alu_op !== 2'b00 || sign_mode !== 1'b1 ||
          state_led !== 2'b10 || op_strobe !== 1'b0) errs++;
    end
    n_total++; if (errs != 0) $display("FAIL sw_noise got %0d unstable cycles exp 0", errs); else n_pass++;
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b1, 8'h00);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_total++; if (reg_a !== 8'h00 || reg_b !== 8'h00)
      $display("FAIL ar_operands got %h/%h exp 00/00", reg_a, reg_b); else n_pass++;
    n_total++; if (alu_op !== 2'b11) $display("FAIL ar_alu_op got %b exp 11", alu_op); else n_pass++;
    n_total++; if (sign_mode !== 1'b0) $display("FAIL ar_sign got %b exp 0", sign_mode); else n_pass++;
    n_total++; if (state_led !== 2'b00) $display("FAIL ar_state got %b exp 00", state_led); else n_pass++;
    n_total++; if (op_strobe !== 1'b0) $display("FAIL ar_strobe got %b exp 0", op_strobe); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h5A);
    n_total++; if (reg_a !== 8'h5A) $display("FAIL ar_recapture_a got %h exp 5A", reg_a); else n_pass++;
    n_total++; if (state_led !== 2'b01) $display("FAIL ar_recapture_state got %b exp 01", state_led); else n_pass++;
  endtask

  task automatic test_enter_held();
    do_reset();
    step(1'b1, 1'b0, 8'h11);
    n_total++; if (state_led !== 2'b01 || reg_a !== 8'h11)
      $display("FAIL held1 got state %b a %h exp 01/11", state_led, reg_a); else n_pass++;
    step(1'b1, 1'b0, 8'h11);
    n_total++; if (state_led !== 2'b10 || reg_b !== 8'h11 || alu_op !== 2'b00)
      $display("FAIL held2 got state %b b %h op %b exp 10/11/00", state_led, reg_b, alu_op); else n_pass++;
    step(1'b1, 1'b0, 8'h11);
    n_total++; if (alu_op !== 2'b01) $display("FAIL held3_op got %b exp 01", alu_op); else n_pass++;
    n_total++; if (op_strobe !== 1'b1) $display("FAIL held3_strobe got %b exp 1", op_strobe); else n_pass++;
    step(1'b0, 1'b0, 8'h00);
    n_total++; if (op_strobe !== 1'b1 || alu_op !== 2'b01)
      $display("FAIL held4 got strobe %b op %b exp 1/01", op_strobe, alu_op); else n_pass++;
    step(1'b0, 1'b0, 8'h00);
    n_total++; if (op_strobe !== 1'b0) $display("FAIL held5_strobe got %b exp 0", op_strobe); else n_pass++;
    n_total++; if (reg_a !== 8'h11 || reg_b !== 8'h11)
      $display("FAIL held_operands got %h/%h exp 11/11", reg_a, reg_b); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_run_steps();
    test_sign_and_enter();
    test_sw_noise();
    test_async_reset();
    test_enter_held();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
